// File: rtl/seg_scan_decoder_pkg.sv
// rtl/seg_scan_decoder_pkg.sv - shared cathode patterns, anode codes and sweep FSM encodings
// Patterns are active-high cathodes, bit order {g,f,e,d,c,b,a}.
package seg_scan_decoder_pkg;

    localparam logic [6:0] SEG_PATTERN_ZERO  = 7'h3F;
    localparam logic [6:0] SEG_PATTERN_ONE   = 7'h06;
    localparam logic [6:0] SEG_PATTERN_TWO   = 7'h5B;
    localparam logic [6:0] SEG_PATTERN_THREE = 7'h4F;
    localparam logic [6:0] SEG_PATTERN_FOUR  = 7'h66;
    localparam logic [6:0] SEG_PATTERN_FIVE  = 7'h6D;
    localparam logic [6:0] SEG_PATTERN_SIX   = 7'h7D;
    localparam logic [6:0] SEG_PATTERN_SEVEN = 7'h07;
    localparam logic [6:0] SEG_PATTERN_EIGHT = 7'h7F;
    localparam logic [6:0] SEG_PATTERN_NINE  = 7'h6F;

    localparam logic [2:0] SEG_ANODE_SECOND = 3'b011;
    localparam logic [2:0] SEG_ANODE_THIRD  = 3'b101;
    localparam logic [2:0] SEG_ANODE_FOURTH = 3'b110;
    localparam logic [2:0] SEG_ANODE_IDLE   = 3'b111;

    typedef enum logic [1:0] {
        WAIT_SECOND = 2'd0,
        WAIT_THIRD  = 2'd1,
        WAIT_FOURTH = 2'd2
    } scan_state_e;

    typedef struct packed {
        logic [3:0] second;
        logic [3:0] third;
        logic [3:0] fourth;
    } frame_t;

    // Only a single low anode line marks a real digit slot.
    function automatic logic is_sample_anode(input logic [2:0] a);
        return (a == SEG_ANODE_SECOND) || (a == SEG_ANODE_THIRD) || (a == SEG_ANODE_FOURTH);
    endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// rtl/seg_pattern_decode.sv - combinational cathode pattern to BCD digit decoder
module seg_pattern_decode
    import seg_scan_decoder_pkg::*;
(
    input  logic [6:0] C,
    output logic       Hit,
    output logic [3:0] Digit
);

    always_comb begin
        Hit   = 1'b1;
        Digit = 4'd0;
        case (C)
            SEG_PATTERN_ZERO:  Digit = 4'd0;
            SEG_PATTERN_ONE:   Digit = 4'd1;
            SEG_PATTERN_TWO:   Digit = 4'd2;
            SEG_PATTERN_THREE: Digit = 4'd3;
            SEG_PATTERN_FOUR:  Digit = 4'd4;
            SEG_PATTERN_FIVE:  Digit = 4'd5;
            SEG_PATTERN_SIX:   Digit = 4'd6;
            SEG_PATTERN_SEVEN: Digit = 4'd7;
            SEG_PATTERN_EIGHT: Digit = 4'd8;
            SEG_PATTERN_NINE:  Digit = 4'd9;
            default: begin
                Hit   = 1'b0;
                Digit = 4'hF;
            end
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - 7-seg scan bus monitor: sweep reassembly, stability and error flags
// Optional SEG_SCAN_ERRCNT_EN adds a saturating ErrorCount output.
module seg_scan_decoder
    import seg_scan_decoder_pkg::*;
#(
    parameter int unsigned STABLE_FRAMES = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [2:0] A,
    input  logic [6:0] C,
    output logic [3:0] SecondDigit,
    output logic [3:0] ThirdDigit,
    output logic [3:0] FourthDigit,
    output logic       FrameValid,
    output logic       Stable,
    output logic       PatternError,
    output logic       SeqError
`ifdef SEG_SCAN_ERRCNT_EN
    ,
    output logic [7:0] ErrorCount
`endif
);

    localparam logic [3:0] STABLE_TH = 4'(STABLE_FRAMES);

    logic        hit;
    logic [3:0]  digit;

    scan_state_e state_q, state_d;
    frame_t      held_q, held_d;
    frame_t      out_q, out_d;
    logic        bad_q, bad_d;
    logic [2:0]  last_a_q, last_a_d;
    logic        frame_valid_q, frame_valid_d;
    logic        stable_q, stable_d;
    logic        pattern_error_q, pattern_error_d;
    logic        seq_error_q, seq_error_d;
    logic [3:0]  stable_cnt_q, stable_cnt_d;
    logic        sample;
    logic        dwell;
    logic        complete;

    seg_pattern_decode u_decode (
        .C     (C),
        .Hit   (hit),
        .Digit (digit)
    );

    assign sample = is_sample_anode(A);
    // A dwell is the same slot seen on back-to-back clocks; idle cycles break it.
    assign dwell  = sample && (A == last_a_q);

    always_comb begin
        state_d         = state_q;
        held_d          = held_q;
        out_d           = out_q;
        bad_d           = bad_q;
        last_a_d        = A;
        frame_valid_d   = 1'b0;
        stable_d        = stable_q;
        pattern_error_d = 1'b0;
        seq_error_d     = 1'b0;
        stable_cnt_d    = stable_cnt_q;
        complete        = 1'b0;

        if (sample) begin
            pattern_error_d = ~hit;
            case (state_q)
                WAIT_SECOND: begin
                    if (A == SEG_ANODE_SECOND) begin
                        held_d.second = digit;
                        bad_d         = ~hit;
                        state_d       = WAIT_THIRD;
                    end
                end
                WAIT_THIRD: begin
                    if (A == SEG_ANODE_SECOND) begin
                        held_d.second = digit;
                        bad_d         = ~hit;
                        seq_error_d   = ~dwell;
                    end else if (A == SEG_ANODE_THIRD) begin
                        held_d.third = digit;
                        bad_d        = bad_q | ~hit;
                        state_d      = WAIT_FOURTH;
                    end else begin
                        seq_error_d = 1'b1;
                        state_d     = WAIT_SECOND;
                    end
                end
                WAIT_FOURTH: begin
                    if (A == SEG_ANODE_SECOND) begin
                        held_d.second = digit;
                        bad_d         = ~hit;
                        seq_error_d   = 1'b1;
                        state_d       = WAIT_THIRD;
                    end else if (A == SEG_ANODE_THIRD) begin
                        if (dwell) begin
                            held_d.third = digit;
                            bad_d        = bad_q | ~hit;
                        end else begin
                            seq_error_d = 1'b1;
                            state_d     = WAIT_SECOND;
                        end
                    end else begin
                        held_d.fourth = digit;
                        bad_d         = bad_q | ~hit;
                        complete      = 1'b1;
                        state_d       = WAIT_SECOND;
                    end
                end
                default: state_d = WAIT_SECOND;
            endcase
        end

        if (complete && !bad_d) begin
            out_d         = held_d;
            frame_valid_d = 1'b1;
            if (held_d == out_q) begin
                stable_cnt_d = (stable_cnt_q == 4'hF) ? 4'hF : stable_cnt_q + 4'd1;
            end else begin
                stable_cnt_d = 4'd1;
            end
            stable_d = (stable_cnt_d >= STABLE_TH);
        end

        // Any error pulse breaks the stability run, overriding a same-cycle frame.
        if (pattern_error_d || seq_error_d) begin
            stable_cnt_d = 4'd0;
            stable_d     = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q         <= WAIT_SECOND;
            held_q          <= '0;
            out_q           <= '0;
            bad_q           <= 1'b0;
            last_a_q        <= SEG_ANODE_IDLE;
            frame_valid_q   <= 1'b0;
            stable_q        <= 1'b0;
            pattern_error_q <= 1'b0;
            seq_error_q     <= 1'b0;
            stable_cnt_q    <= 4'd0;
        end else begin
            state_q         <= state_d;
            held_q          <= held_d;
            out_q           <= out_d;
            bad_q           <= bad_d;
            last_a_q        <= last_a_d;
            frame_valid_q   <= frame_valid_d;
            stable_q        <= stable_d;
            pattern_error_q <= pattern_error_d;
            seq_error_q     <= seq_error_d;
            stable_cnt_q    <= stable_cnt_d;
        end
    end

    assign SecondDigit  = out_q.second;
    assign ThirdDigit   = out_q.third;
    assign FourthDigit  = out_q.fourth;
    assign FrameValid   = frame_valid_q;
    assign Stable       = stable_q;
    assign PatternError = pattern_error_q;
    assign SeqError     = seq_error_q;

`ifdef SEG_SCAN_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((pattern_error_d || seq_error_d) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign ErrorCount = err_cnt_q;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - scoreboard bench for seg_scan_decoder (optionally SEG_SCAN_ERRCNT_EN)
module tb_seg_scan_decoder;

    localparam logic [2:0] AN_SEC  = 3'b011;
    localparam logic [2:0] AN_THI  = 3'b101;
    localparam logic [2:0] AN_FOU  = 3'b110;
    localparam logic [2:0] AN_IDLE = 3'b111;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [2:0] A = AN_IDLE;
    logic [6:0] C = 7'h00;
    logic [3:0] SecondDigit, ThirdDigit, FourthDigit;
    logic       FrameValid, Stable, PatternError, SeqError;
`ifdef SEG_SCAN_ERRCNT_EN
    logic [7:0] ErrorCount;
`endif

    seg_scan_decoder #(.STABLE_FRAMES(2)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .A            (A),
        .C            (C),
        .SecondDigit  (SecondDigit),
        .ThirdDigit   (ThirdDigit),
        .FourthDigit  (FourthDigit),
        .FrameValid   (FrameValid),
        .Stable       (Stable),
        .PatternError (PatternError),
        .SeqError     (SeqError)
`ifdef SEG_SCAN_ERRCNT_EN
        ,
        .ErrorCount   (ErrorCount)
`endif
    );

    always #5 Clock = ~Clock;

    int unsigned cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [6:0] pat_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    typedef struct {
        int unsigned cyc;
        logic [3:0]  d2, d3, d4;
        logic        st;
    } frame_exp_t;

    typedef struct {
        int unsigned cyc;
        logic        pe, se;
    } err_exp_t;

    frame_exp_t frame_q[$];
    err_exp_t   err_q[$];

    logic [3:0] m2 = 0, m3 = 0, m4 = 0;
    int         m_cnt = 0;

    task automatic drive(input logic [2:0] a, input logic [6:0] c);
        @(negedge Clock);
        A = a;
        C = c;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(AN_IDLE, 7'h00);
    endtask

    // Called right after driving the Fourth slot of a clean sweep.
    task automatic expect_frame(input logic [3:0] d2, input logic [3:0] d3, input logic [3:0] d4);
        frame_exp_t fe;
        if (d2 == m2 && d3 == m3 && d4 == m4) m_cnt = (m_cnt >= 15) ? 15 : m_cnt + 1;
        else m_cnt = 1;
        m2 = d2; m3 = d3; m4 = d4;
        fe.cyc = cyc + 1; fe.d2 = d2; fe.d3 = d3; fe.d4 = d4; fe.st = (m_cnt >= 2);
        frame_q.push_back(fe);
    endtask

    task automatic expect_err(input logic pe, input logic se);
        err_exp_t ee;
        ee.cyc = cyc + 1; ee.pe = pe; ee.se = se;
        err_q.push_back(ee);
        m_cnt = 0;
    endtask

    task automatic sweep(input logic [3:0] d2, input logic [3:0] d3, input logic [3:0] d4, input int gap);
        drive(AN_SEC, pat_tab[d2]);
        idle(gap);
        drive(AN_THI, pat_tab[d3]);
        idle(gap);
        drive(AN_FOU, pat_tab[d4]);
        expect_frame(d2, d3, d4);
    endtask

    task automatic check_outputs(input string tag);
        check_eq({tag, "_second"}, SecondDigit, m2);
        check_eq({tag, "_third"},  ThirdDigit,  m3);
        check_eq({tag, "_fourth"}, FourthDigit, m4);
        check_eq({tag, "_stable"}, Stable, (m_cnt >= 2));
    endtask

    always @(posedge Clock) begin
        frame_exp_t fe;
        err_exp_t   ee;
        #1;
        while (frame_q.size() > 0 && frame_q[0].cyc < cyc) begin
            check_eq("missing_framevalid", 0, 1);
            void'(frame_q.pop_front());
        end
        while (err_q.size() > 0 && err_q[0].cyc < cyc) begin
            check_eq("missing_error_pulse", 0, 1);
            void'(err_q.pop_front());
        end
        if (FrameValid) begin
            if (frame_q.size() == 0) begin
                check_eq("unexpected_framevalid", 1, 0);
            end else begin
                fe = frame_q.pop_front();
                check_eq("fv_cycle", cyc, fe.cyc);
                check_eq("fv_second", SecondDigit, fe.d2);
                check_eq("fv_third", ThirdDigit, fe.d3);
                check_eq("fv_fourth", FourthDigit, fe.d4);
                check_eq("fv_stable", Stable, fe.st);
            end
        end
        if (PatternError || SeqError) begin
            if (err_q.size() == 0) begin
                check_eq("unexpected_error_pulse", {PatternError, SeqError}, 0);
            end else begin
                ee = err_q.pop_front();
                check_eq("err_cycle", cyc, ee.cyc);
                check_eq("pattern_error", PatternError, ee.pe);
                check_eq("seq_error", SeqError, ee.se);
                check_eq("err_stable_clear", Stable, 0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge Clock);
        check_eq("rst_second", SecondDigit, 0);
        check_eq("rst_third", ThirdDigit, 0);
        check_eq("rst_fourth", FourthDigit, 0);
        check_eq("rst_fv", FrameValid, 0);
        check_eq("rst_stable", Stable, 0);
        check_eq("rst_pe", PatternError, 0);
        check_eq("rst_se", SeqError, 0);
`ifdef SEG_SCAN_ERRCNT_EN
        check_eq("rst_errcnt", ErrorCount, 0);
`endif
        Reset = 1'b0;

        // Repeating clean sweep, then a changed Third digit.
        for (int i = 0; i < 3; i++) sweep(3, 7, 9, 0);
        sweep(3, 4, 9, 0);
        sweep(3, 4, 9, 0);
        sweep(3, 7, 9, 0);
        sweep(3, 7, 9, 0);

        // Bad cathode on the Third slot.
        drive(AN_SEC, pat_tab[3]);
        drive(AN_THI, 7'h00);
        expect_err(1, 0);
        drive(AN_FOU, pat_tab[9]);
        idle(2);
        check_outputs("after_bad_pattern");
        sweep(3, 7, 9, 0);
        sweep(3, 7, 9, 0);

        // Second followed directly by Fourth.
        drive(AN_SEC, pat_tab[3]);
        drive(AN_FOU, pat_tab[9]);
        expect_err(0, 1);
        sweep(3, 7, 9, 0);
        sweep(3, 7, 9, 0);

        // Idle cycles between every slot and between sweeps.
        for (int i = 0; i < 2; i++) begin
            sweep(5, 0, 8, 1);
            idle(1);
        end

        // Driver dwelling on Second and Third; last sample wins.
        drive(AN_SEC, pat_tab[1]);
        drive(AN_SEC, pat_tab[2]);
        drive(AN_THI, pat_tab[6]);
        drive(AN_THI, pat_tab[0]);
        drive(AN_FOU, pat_tab[4]);
        expect_frame(2, 0, 4);

        // Bad Fourth pattern: error wins over frame completion.
        drive(AN_SEC, pat_tab[2]);
        drive(AN_THI, pat_tab[0]);
        drive(AN_FOU, 7'h00);
        expect_err(1, 0);
        idle(2);
        check_outputs("after_bad_fourth");

        // Second arriving in WAIT_FOURTH restarts the sweep.
        drive(AN_SEC, pat_tab[1]);
        drive(AN_THI, pat_tab[1]);
        drive(AN_SEC, pat_tab[2]);
        expect_err(0, 1);
        drive(AN_THI, pat_tab[3]);
        drive(AN_FOU, pat_tab[4]);
        expect_frame(2, 3, 4);

        // Hunting in WAIT_SECOND and multi-low anode values are silent.
        drive(AN_FOU, pat_tab[9]);
        drive(AN_THI, pat_tab[9]);
        drive(AN_SEC, pat_tab[5]);
        drive(3'b000, 7'h00);
        drive(3'b001, pat_tab[1]);
        drive(AN_THI, pat_tab[5]);
        drive(AN_FOU, pat_tab[5]);
        expect_frame(5, 5, 5);
        idle(2);

        // Reset while waiting for Fourth: partial sweep is dropped.
        drive(AN_SEC, pat_tab[3]);
        drive(AN_THI, pat_tab[7]);
        @(negedge Clock);
        Reset = 1'b1;
        A = AN_IDLE;
        @(negedge Clock);
        Reset = 1'b0;
        m2 = 0; m3 = 0; m4 = 0; m_cnt = 0;
        check_outputs("after_reset");
        check_eq("after_reset_fv", FrameValid, 0);
`ifdef SEG_SCAN_ERRCNT_EN
        check_eq("after_reset_errcnt", ErrorCount, 0);
`endif
        drive(AN_FOU, pat_tab[9]);
        idle(3);
        check_outputs("after_reset_partial");
        sweep(3, 7, 9, 0);
        idle(2);

`ifdef SEG_SCAN_ERRCNT_EN
        for (int i = 0; i < 300; i++) begin
            drive(AN_SEC, 7'h00);
            expect_err(1, 0);
        end
        idle(3);
        check_eq("errcnt_saturate", ErrorCount, 8'd255);
`endif

        idle(5);
        check_eq("frame_queue_drained", frame_q.size(), 0);
        check_eq("error_queue_drained", err_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
